// File: rtl/aap_pkg.sv
// Shared definitions for decode, the sequencer and the execution unit:
// operation numbers, field widths and the sequencer state encoding.
package aap_pkg;

    localparam int OP_W   = 6;
    localparam int RF_W   = 3;
    localparam int CNT_W  = 16;
    localparam int IMM1_W = 3;
    localparam int IMM2_W = 6;
    localparam int IMM3_W = 9;

    localparam int OP_NOP  = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_AND  = 3;
    localparam int OP_OR   = 4;
    localparam int OP_XOR  = 5;
    localparam int OP_SHL  = 6;
    localparam int OP_SHR  = 7;
    localparam int OP_CMP  = 8;
    localparam int OP_MOV  = 9;
    localparam int OP_ADDI = 10;
    localparam int OP_SUBI = 11;
    localparam int OP_ANDI = 12;
    localparam int OP_ORI  = 13;
    localparam int OP_SHLI = 14;
    localparam int OP_LUI  = 15;
    localparam int OP_LDB  = 16;
    localparam int OP_LDW  = 17;
    localparam int OP_LAST = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_LOAD,
        ST_RETIRE
    } seq_state_t;

endpackage

// File: rtl/exec_sequencer_op_classify.sv
// Combinational op classifier used at issue time.
// Ports: op in; skip (bypass READ/EXEC), load (extra mem cycle), illegal out.
module op_classify
    import aap_pkg::*;
#(
    parameter int OPW = OP_W
) (
    input  logic [OPW-1:0] op,
    output logic           skip,
    output logic           load,
    output logic           illegal
);

    always_comb begin
        illegal = op > OPW'(OP_LAST);
        // Moves are not yet wired in the execution unit, so they retire
        // without ever being shown to it.
        skip    = (op == OPW'(OP_NOP)) || (op == OPW'(OP_MOV)) || illegal;
        load    = (op == OPW'(OP_LDB)) || (op == OPW'(OP_LDW));
    end

endmodule

// File: rtl/exec_sequencer.sv
// Single-issue sequencer between decode and the execution unit.
// Ports: clock/reset; issue_* valid/ready handshake in; exec_* latched
// fields out; retire/illegal pulses; busy; retired_count.
module exec_sequencer
    import aap_pkg::*;
#(
    parameter int OPW  = OP_W,
    parameter int RFW  = RF_W,
    parameter int CNTW = CNT_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [OPW-1:0]  issue_op,
    input  logic [RFW-1:0]  issue_dest,
    input  logic [RFW-1:0]  issue_src1,
    input  logic [RFW-1:0]  issue_src2,
    input  logic [2:0]      issue_imm1,
    input  logic [5:0]      issue_imm2,
    input  logic [8:0]      issue_imm3,
    output logic [OPW-1:0]  exec_op,
    output logic [RFW-1:0]  exec_dest,
    output logic [RFW-1:0]  exec_src1,
    output logic [RFW-1:0]  exec_src2,
    output logic [2:0]      exec_imm1,
    output logic [5:0]      exec_imm2,
    output logic [8:0]      exec_imm3,
    output logic            retire,
    output logic            illegal,
    output logic            busy,
    output logic [CNTW-1:0] retired_count
);

    seq_state_t     state;
    seq_state_t     state_next;
    logic [OPW-1:0] op_q;
    logic [OPW-1:0] exec_op_next;
    logic           load_q;
    logic           illegal_q;
    logic           accept;
    logic           cls_skip;
    logic           cls_load;
    logic           cls_illegal;

    op_classify #(.OPW(OPW)) u_classify (
        .op      (issue_op),
        .skip    (cls_skip),
        .load    (cls_load),
        .illegal (cls_illegal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        exec_op_next = '0;
        issue_ready  = 1'b0;
        retire       = 1'b0;
        illegal      = 1'b0;
        busy         = (state != ST_IDLE);
        unique case (state)
            ST_IDLE: begin
                issue_ready = 1'b1;
            end
            ST_READ: begin
                state_next   = ST_EXEC;
                exec_op_next = op_q;
            end
            ST_EXEC: begin
                // Loads keep the op up one more cycle so the memory read
                // data is valid for write-back.
                if (load_q) begin
                    state_next   = ST_LOAD;
                    exec_op_next = op_q;
                end else begin
                    state_next = ST_RETIRE;
                end
            end
            ST_LOAD: begin
                state_next = ST_RETIRE;
            end
            ST_RETIRE: begin
                issue_ready = 1'b1;
                retire      = 1'b1;
                illegal     = illegal_q;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        accept = issue_ready && issue_valid;
        if (accept) begin
            state_next = cls_skip ? ST_RETIRE : ST_READ;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            exec_op       <= '0;
            op_q          <= '0;
            load_q        <= 1'b0;
            illegal_q     <= 1'b0;
            exec_dest     <= '0;
            exec_src1     <= '0;
            exec_src2     <= '0;
            exec_imm1     <= '0;
            exec_imm2     <= '0;
            exec_imm3     <= '0;
            retired_count <= '0;
        end else begin
            exec_op <= exec_op_next;
            if (accept) begin
                op_q      <= issue_op;
                load_q    <= cls_load;
                illegal_q <= cls_illegal;
                exec_dest <= issue_dest;
                exec_src1 <= issue_src1;
                exec_src2 <= issue_src2;
                exec_imm1 <= issue_imm1;
                exec_imm2 <= issue_imm2;
                exec_imm3 <= issue_imm3;
            end
            if (state == ST_RETIRE) begin
                retired_count <= retired_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: directed scenarios plus random
// traffic, checked each cycle against a timing model of each issued op.
module tb_exec_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       issue_valid = 1'b0;
    logic       issue_ready;
    logic [5:0] issue_op = '0;
    logic [2:0] issue_dest = '0;
    logic [2:0] issue_src1 = '0;
    logic [2:0] issue_src2 = '0;
    logic [2:0] issue_imm1 = '0;
    logic [5:0] issue_imm2 = '0;
    logic [8:0] issue_imm3 = '0;
    logic [5:0] exec_op;
    logic [2:0] exec_dest;
    logic [2:0] exec_src1;
    logic [2:0] exec_src2;
    logic [2:0] exec_imm1;
    logic [5:0] exec_imm2;
    logic [8:0] exec_imm3;
    logic       retire;
    logic       illegal;
    logic       busy;
    logic [3:0] retired_count;

    exec_sequencer #(.OPW(6), .RFW(3), .CNTW(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_op      (issue_op),
        .issue_dest    (issue_dest),
        .issue_src1    (issue_src1),
        .issue_src2    (issue_src2),
        .issue_imm1    (issue_imm1),
        .issue_imm2    (issue_imm2),
        .issue_imm3    (issue_imm3),
        .exec_op       (exec_op),
        .exec_dest     (exec_dest),
        .exec_src1     (exec_src1),
        .exec_src2     (exec_src2),
        .exec_imm1     (exec_imm1),
        .exec_imm2     (exec_imm2),
        .exec_imm3     (exec_imm3),
        .retire        (retire),
        .illegal       (illegal),
        .busy          (busy),
        .retired_count (retired_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        int op;
        int fields;
        bit ill;
        int acc;
        int ret;
        int nx;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;
    bit   mon_en = 1'b0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic int pack_fields(int d, int s1, int s2,
                                       int i1, int i2, int i3);
        return (d & 7) << 27 | (s1 & 7) << 24 | (s2 & 7) << 21 |
               (i1 & 7) << 18 | (i2 & 63) << 12 | (i3 & 511) << 3;
    endfunction

    // Monitor: compares every output against the op at the head of the
    // scoreboard, using the latency rules of each op class.
    exp_t h;
    bit   has;
    bit   rexp;
    int   xop;
    int   k;
    always @(negedge clock) begin
        if (mon_en) begin
            k    = cyc;
            has  = (q.size() > 0);
            rexp = 1'b0;
            xop  = 0;
            h    = '{default: 0};
            if (has) begin
                h    = q[0];
                rexp = (k == h.ret);
                if (k >= h.acc + 2 && k < h.acc + 2 + h.nx) xop = h.op;
            end
            chk("issue_ready", int'(issue_ready), int'(!has || rexp));
            chk("busy", int'(busy), int'(has));
            chk("retire", int'(retire), int'(rexp));
            chk("illegal", int'(illegal), int'(rexp && h.ill));
            chk("exec_op", int'(exec_op), xop);
            chk("retired_count", int'(retired_count), exp_count % 16);
            if (has && k >= h.acc + 1) begin
                chk("exec_fields",
                    pack_fields(exec_dest, exec_src1, exec_src2,
                                exec_imm1, exec_imm2, exec_imm3),
                    h.fields);
            end
            if (rexp) begin
                void'(q.pop_front());
                exp_count++;
            end else if (has && k > h.ret) begin
                void'(q.pop_front());
            end
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clock);
            #1;
            issue_valid = 1'b0;
        end
    endtask

    task automatic issue(int op, int d, int s1, int s2,
                         int i1, int i2, int i3);
        bit   done = 1'b0;
        bit   skip;
        bit   load;
        exp_t e;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clock);
            #1;
            issue_valid = 1'b1;
            issue_op    = 6'(op);
            issue_dest  = 3'(d);
            issue_src1  = 3'(s1);
            issue_src2  = 3'(s2);
            issue_imm1  = 3'(i1);
            issue_imm2  = 6'(i2);
            issue_imm3  = 9'(i3);
            if (issue_ready) begin
                skip     = (op == 0) || (op == 9) || (op >= 18);
                load     = (op == 16) || (op == 17);
                e.op     = op;
                e.fields = pack_fields(d, s1, s2, i1, i2, i3);
                e.ill    = (op >= 18);
                e.acc    = cyc;
                e.ret    = cyc + (skip ? 1 : (load ? 4 : 3));
                e.nx     = skip ? 0 : (load ? 2 : 1);
                q.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: ready stayed 0, required 1");
        end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clock);
        chk("reset_fields",
            pack_fields(exec_dest, exec_src1, exec_src2,
                        exec_imm1, exec_imm2, exec_imm3), 0);

        issue(1, 2, 3, 4, 0, 0, 0);
        idle(4);
        issue(17, 5, 0, 0, 2, 0, 0);
        idle(5);
        repeat (10) issue(0, 1, 1, 1, 1, 1, 1);
        idle(2);
        issue(25, 6, 5, 4, 3, 2, 1);
        idle(2);

        issue(3, 1, 2, 3, 4, 5, 6);
        idle(1);
        @(negedge clock);
        #1;
        reset = 1'b1;
        q.delete();
        exp_count = 0;
        @(negedge clock);
        #1;
        reset = 1'b0;
        issue(2, 7, 6, 5, 7, 63, 511);
        idle(4);

        repeat (16) issue(0, 0, 0, 0, 0, 0, 0);
        idle(2);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            issue($urandom_range(0, 40), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 63),
                  $urandom_range(0, 511));
        end
        idle(1);
        for (int t = 0; t < 30 && q.size() > 0; t++) @(negedge clock);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d ops outstanding, required 0", q.size());
        end
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
